// File: rtl/spi_reg_peripheral_if.sv
// SPI pin bundle between an external controller (master) and the register peripheral (slave).
interface spi_reg_peripheral_if;
  logic sclk;
  logic copi;
  logic ncs;
  logic cipo;

  modport master (output sclk, output copi, output ncs, input cipo);
  modport slave  (input sclk, input copi, input ncs, output cipo);
endinterface

// File: rtl/spi_reg_peripheral.sv
// Mode-0 SPI target decoding 16-bit {rw, addr[6:0], data[7:0]} frames into five 8-bit registers.
// Optional readback of registers on cipo is enabled by defining SPI_READBACK_EN.
module spi_reg_peripheral #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [6:0]  MAX_ADDR    = 7'h04
) (
  input  logic                 clk,
  input  logic                 rst_n,
  spi_reg_peripheral_if.slave  spi,
  output logic [7:0]           en_reg_out_7_0,
  output logic [7:0]           en_reg_out_15_8,
  output logic [7:0]           en_reg_pwm_7_0,
  output logic [7:0]           en_reg_pwm_15_8,
  output logic [7:0]           pwm_duty_cycle,
  output logic                 frame_done
);

  localparam int NumRegs = 5;

  logic [SYNC_STAGES-1:0] sclk_sync_q, copi_sync_q, ncs_sync_q;
  logic                   sclk_prev_q, ncs_prev_q;
  logic                   sclk_s, copi_s, ncs_s;
  logic                   sclk_rise, ncs_rise, ncs_fall;

  logic [4:0]  count_q;
  logic [15:0] shift_q;
  logic        ovf_q;
  logic        frame_valid;

  logic        commit_q;
  logic [6:0]  commit_addr_q;
  logic [7:0]  commit_data_q;
  logic        frame_done_q;
  logic [7:0]  regs_q [NumRegs];

  // ncs synchroniser idles high so reset release never looks like a frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      copi_sync_q <= '0;
      ncs_sync_q  <= '1;
      sclk_prev_q <= 1'b0;
      ncs_prev_q  <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi.sclk};
      copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], spi.copi};
      ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], spi.ncs};
      sclk_prev_q <= sclk_s;
      ncs_prev_q  <= ncs_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign copi_s    = copi_sync_q[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign ncs_rise  = ncs_s & ~ncs_prev_q;
  assign ncs_fall  = ~ncs_s & ncs_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      shift_q <= '0;
      ovf_q   <= 1'b0;
    end else if (ncs_fall) begin
      count_q <= '0;
      shift_q <= '0;
      ovf_q   <= 1'b0;
    end else if (sclk_rise && !ncs_s) begin
      if (count_q == 5'd16) begin
        ovf_q <= 1'b1;
      end else begin
        shift_q <= {shift_q[14:0], copi_s};
        count_q <= count_q + 5'd1;
      end
    end
  end

  always_comb begin
    frame_valid = (count_q == 5'd16) && !ovf_q && shift_q[15] &&
                  (shift_q[14:8] <= MAX_ADDR) && (shift_q[14:8] < 7'(NumRegs));
  end

  // Commit is staged one clk after the ncs edge; the register write and frame_done share a cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      commit_q      <= 1'b0;
      commit_addr_q <= '0;
      commit_data_q <= '0;
      frame_done_q  <= 1'b0;
      for (int i = 0; i < NumRegs; i++) regs_q[i] <= '0;
    end else begin
      commit_q      <= ncs_rise && frame_valid;
      commit_addr_q <= shift_q[14:8];
      commit_data_q <= shift_q[7:0];
      frame_done_q  <= commit_q;
      for (int i = 0; i < NumRegs; i++) begin
        if (commit_q && commit_addr_q == 7'(i)) regs_q[i] <= commit_data_q;
      end
    end
  end

  assign en_reg_out_7_0  = regs_q[0];
  assign en_reg_out_15_8 = regs_q[1];
  assign en_reg_pwm_7_0  = regs_q[2];
  assign en_reg_pwm_15_8 = regs_q[3];
  assign pwm_duty_cycle  = regs_q[4];
  assign frame_done      = frame_done_q;

`ifdef SPI_READBACK_EN
  logic       sclk_fall;
  logic [6:0] rd_addr;
  logic [7:0] rd_val;
  logic [7:0] tx_q;
  logic       cipo_q;

  assign sclk_fall = ~sclk_s & sclk_prev_q;
  // Address as it will stand once the 8th bit is shifted in.
  assign rd_addr   = {shift_q[5:0], copi_s};

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NumRegs; i++) begin
      if (rd_addr == 7'(i) && rd_addr <= MAX_ADDR) rd_val = regs_q[i];
    end
  end

  // tx_q empties to zero after eight falls, so cipo returns low without extra bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_q   <= '0;
      cipo_q <= 1'b0;
    end else if (ncs_s) begin
      tx_q   <= '0;
      cipo_q <= 1'b0;
    end else if (sclk_rise && count_q == 5'd7) begin
      tx_q <= shift_q[6] ? 8'h00 : rd_val;
    end else if (sclk_fall) begin
      cipo_q <= tx_q[7];
      tx_q   <= {tx_q[6:0], 1'b0};
    end
  end

  assign spi.cipo = cipo_q;
`else
  assign spi.cipo = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_peripheral.sv
// Frame-level register model checked every clk against spi_reg_peripheral, plus literal pins.
module tb_spi_reg_peripheral;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
  logic       frame_done;

  spi_reg_peripheral_if spi ();

  spi_reg_peripheral dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .spi             (spi),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .frame_done      (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    int         addr;
    logic [7:0] data;
  } ev_t;

  ev_t        pend[$];
  logic [7:0] exp_reg [5];
  logic       exp_done;
  int         cyc = 0;
  int         done_cnt = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic       in_read = 1'b0;
  logic [7:0] rx;

  localparam int Half = 6;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, exp);
    end
  endtask

  // Model: a frame's effect lands four clk edges after ncs goes high.
  always @(posedge clk) begin
    cyc++;
    exp_done = 1'b0;
    if (rst_n && pend.size() > 0 && pend[0].due == cyc) begin
      exp_reg[pend[0].addr] = pend[0].data;
      exp_done = 1'b1;
      void'(pend.pop_front());
    end
    #1;
    if (frame_done === 1'b1) done_cnt++;
    check("reg0", {24'h0, en_reg_out_7_0}, {24'h0, exp_reg[0]});
    check("reg1", {24'h0, en_reg_out_15_8}, {24'h0, exp_reg[1]});
    check("reg2", {24'h0, en_reg_pwm_7_0}, {24'h0, exp_reg[2]});
    check("reg3", {24'h0, en_reg_pwm_15_8}, {24'h0, exp_reg[3]});
    check("reg4", {24'h0, pwm_duty_cycle}, {24'h0, exp_reg[4]});
    check("frame_done", {31'h0, frame_done}, {31'h0, exp_done});
`ifdef SPI_READBACK_EN
    if (!in_read) check("cipo_idle", {31'h0, spi.cipo}, 32'h0);
`else
    check("cipo_tied", {31'h0, spi.cipo}, 32'h0);
`endif
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Clocks n bits MSB-first; cipo is sampled just before each rise, as a mode-0 controller does.
  task automatic shift_bits(input logic [31:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      spi.copi = bits[n-1-i];
      wait_clk(Half);
      if (i >= 8 && i < 16) rx = {rx[6:0], spi.cipo};
      spi.sclk = 1'b1;
      wait_clk(Half);
      spi.sclk = 1'b0;
      wait_clk(Half);
    end
  endtask

  task automatic send_frame(input logic [31:0] bits, input int n);
    ev_t ev;
    rx = 8'h00;
    in_read = (n == 16) && !bits[15];
    spi.ncs = 1'b0;
    wait_clk(Half);
    shift_bits(bits, n);
    spi.ncs = 1'b1;
    in_read = 1'b0;
    if (n == 16 && bits[15] && bits[14:8] <= 7'h04) begin
      ev.due  = cyc + 4;
      ev.addr = int'(bits[14:8]);
      ev.data = bits[7:0];
      pend.push_back(ev);
    end
    wait_clk(10);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    spi.ncs  = 1'b1;
    spi.sclk = 1'b0;
    spi.copi = 1'b0;
    pend.delete();
    for (int i = 0; i < 5; i++) exp_reg[i] = 8'h00;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(4);
  endtask

  int d0;

  initial begin
    for (int i = 0; i < 5; i++) exp_reg[i] = 8'h00;
    spi.ncs  = 1'b1;
    spi.sclk = 1'b0;
    spi.copi = 1'b0;
    @(negedge clk);
    do_reset();
    check("rst_regs", {en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8},
          32'h0000_0000);
    check("rst_duty", {24'h0, pwm_duty_cycle}, 32'h0);
    check("rst_done_cipo", {30'h0, frame_done, spi.cipo}, 32'h0);

    d0 = done_cnt;
    send_frame(32'h80F0, 16);
    check("wr0_val", {24'h0, en_reg_out_7_0}, 32'hF0);
    check("wr0_others", {en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle},
          32'h0);
    check("wr0_pulses", done_cnt - d0, 1);

    d0 = done_cnt;
    send_frame(32'h84A5, 16);
    send_frame(32'h8533, 16);
    check("wr4_val", {24'h0, pwm_duty_cycle}, 32'hA5);
    check("addr5_pulses", done_cnt - d0, 1);

    d0 = done_cnt;
    send_frame(32'h0811, 12);
    send_frame(32'h1_0222, 17);
    check("short_long_val", {24'h0, en_reg_out_15_8}, 32'h00);
    check("short_long_pulses", done_cnt - d0, 0);

    send_frame(32'h8480, 16);
    d0 = done_cnt;
    send_frame(32'h0400, 16);
    check("read_keeps", {24'h0, pwm_duty_cycle}, 32'h80);
    check("read_pulses", done_cnt - d0, 0);
`ifdef SPI_READBACK_EN
    check("readback_bits", {24'h0, rx}, 32'h80);
`else
    check("readback_bits", {24'h0, rx}, 32'h00);
`endif

    d0 = done_cnt;
    spi.ncs = 1'b0;
    wait_clk(Half);
    shift_bits(32'h83, 8);
    do_reset();
    check("midreset_regs", {en_reg_out_7_0, pwm_duty_cycle, en_reg_pwm_15_8}, 24'h0);
    send_frame(32'h8340, 16);
    check("post_reset_val", {24'h0, en_reg_pwm_15_8}, 32'h40);
    check("post_reset_pulses", done_cnt - d0, 1);

    wait_clk(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
